// File: rtl/multicycle_controller.sv
// Multi-cycle accumulator-CPU controller: FETCH / EXEC / IMM / HALTED sequencing with a
// memory-ready handshake, conditional jumps, illegal-opcode trap and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned ALU_SEL_W    = 4,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter int unsigned ILLEGAL_TRAP = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 CLB,
  input  logic [3:0]           op,
  input  logic                 z,
  input  logic                 c,
  input  logic                 mem_ready,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 SelPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelACC,
  output logic [ALU_SEL_W-1:0] SelALU,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int unsigned WaitW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_CYCLES);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpNor  = 4'b0011;
  localparam logic [3:0] OpMovr = 4'b0100;
  localparam logic [3:0] OpMova = 4'b0101;
  localparam logic [3:0] OpJzrs = 4'b0110;
  localparam logic [3:0] OpJzim = 4'b0111;
  localparam logic [3:0] OpJcrs = 4'b1000;
  localparam logic [3:0] OpIll0 = 4'b1001;
  localparam logic [3:0] OpJcim = 4'b1010;
  localparam logic [3:0] OpShl  = 4'b1011;
  localparam logic [3:0] OpShr  = 4'b1100;
  localparam logic [3:0] OpLdim = 4'b1101;
  localparam logic [3:0] OpIll1 = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;

  typedef enum logic [1:0] {StFetch, StExec, StImm, StHalted} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             retire;
  logic [3:0]       alu_sel;

  // The wait counter saturates at WaitMax, so equality is the ">=" test.
  assign accept      = mem_ready && (wait_q == WaitMax);
  assign SelALU      = ALU_SEL_W'(alu_sel);
  assign instr_count = CLB ? '0 : cnt_q;

  always_comb begin
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelACC  = 2'b00;
    alu_sel = 4'b0000;
    halted  = 1'b0;
    illegal = 1'b0;
    retire  = 1'b0;
    state_d = state_q;
    taken_d = taken_q;

    unique case (state_q)
      StFetch: begin
        if (accept) begin
          LoadIR  = 1'b1;
          IncPC   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        retire  = 1'b1;
        case (op)
          OpAdd:  begin LoadAcc = 1'b1; SelACC = 2'b10; alu_sel = 4'b1000; end
          OpSub:  begin LoadAcc = 1'b1; SelACC = 2'b10; alu_sel = 4'b1100; end
          OpNor:  begin LoadAcc = 1'b1; SelACC = 2'b10; alu_sel = 4'b0100; end
          OpShl:  begin LoadAcc = 1'b1; SelACC = 2'b10; alu_sel = 4'b0001; end
          OpShr:  begin LoadAcc = 1'b1; SelACC = 2'b10; alu_sel = 4'b0011; end
          OpMovr: LoadReg = 1'b1;
          OpMova: begin LoadAcc = 1'b1; SelACC = 2'b01; end
          OpJzrs: LoadPC = z;
          OpJcrs: LoadPC = c;
          OpJzim: begin taken_d = z;    state_d = StImm; retire = 1'b0; end
          OpJcim: begin taken_d = c;    state_d = StImm; retire = 1'b0; end
          OpLdim: begin taken_d = 1'b0; state_d = StImm; retire = 1'b0; end
          OpHalt: begin state_d = StHalted; retire = 1'b0; end
          OpIll0, OpIll1: begin
            illegal = 1'b1;
            if (ILLEGAL_TRAP != 0) begin
              state_d = StHalted;
              retire  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      StImm: begin
        if (accept) begin
          state_d = StFetch;
          retire  = 1'b1;
          if (op == OpLdim) begin
            LoadAcc = 1'b1;
            alu_sel = 4'b0010;
            IncPC   = 1'b1;
          end else if (taken_q) begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
          end else begin
            IncPC = 1'b1;  // skip the immediate word
          end
        end
      end
      StHalted: halted = 1'b1;
      default: ;
    endcase

    if (CLB) begin
      LoadIR  = 1'b0;
      IncPC   = 1'b0;
      SelPC   = 1'b0;
      LoadPC  = 1'b0;
      LoadReg = 1'b0;
      LoadAcc = 1'b0;
      SelACC  = 2'b00;
      alu_sel = 4'b0000;
      halted  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q <= StFetch;
      wait_q  <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      taken_q <= taken_d;
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: four instances with different parameters, each
// exercised in turn against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int NI = 4;

  localparam logic [11:0] SIr   = 12'h800;
  localparam logic [11:0] SInc  = 12'h400;
  localparam logic [11:0] SSpc  = 12'h200;
  localparam logic [11:0] SLpc  = 12'h100;
  localparam logic [11:0] SLreg = 12'h080;
  localparam logic [11:0] SLacc = 12'h040;
  localparam logic [11:0] SAccA = 12'h020;
  localparam logic [11:0] SAccR = 12'h010;

  logic       clk = 1'b0;
  logic [3:0] op;
  logic       z, c, mem_ready;
  logic       clb      [NI];
  logic       load_ir  [NI];
  logic       inc_pc   [NI];
  logic       sel_pc   [NI];
  logic       load_pc  [NI];
  logic       load_reg [NI];
  logic       load_acc [NI];
  logic       halted   [NI];
  logic       illegal  [NI];
  logic [1:0] sel_acc  [NI];
  logic [3:0] sel_alu  [NI];
  logic [15:0] cnt     [NI];

  always #5 clk = ~clk;

  // 0: defaults, 1: two wait cycles, 2: illegal executes as NOP, 3: 2-bit counter
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned CW = (g == 3) ? 2 : 16;
    logic [CW-1:0] cnt_raw;
    multicycle_controller #(
      .ALU_SEL_W    (4),
      .WAIT_CYCLES  ((g == 1) ? 2 : 0),
      .ILLEGAL_TRAP ((g == 2) ? 0 : 1),
      .CNT_W        (CW)
    ) u_dut (
      .clk         (clk),
      .CLB         (clb[g]),
      .op          (op),
      .z           (z),
      .c           (c),
      .mem_ready   (mem_ready),
      .LoadIR      (load_ir[g]),
      .IncPC       (inc_pc[g]),
      .SelPC       (sel_pc[g]),
      .LoadPC      (load_pc[g]),
      .LoadReg     (load_reg[g]),
      .LoadAcc     (load_acc[g]),
      .SelACC      (sel_acc[g]),
      .SelALU      (sel_alu[g]),
      .halted      (halted[g]),
      .illegal     (illegal[g]),
      .instr_count (cnt_raw)
    );
    assign cnt[g] = 16'(cnt_raw);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int m_count;
  int m_age;
  bit g_mr_hold;

  function automatic int wait_of(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic bit trap_of(int k);
    return k != 2;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 3) ? 3 : 65535;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] got_strobes(int k);
    return {load_ir[k], inc_pc[k], sel_pc[k], load_pc[k], load_reg[k], load_acc[k],
            sel_acc[k], sel_alu[k]};
  endfunction

  // Expected EXEC-cycle strobes straight from the opcode table.
  function automatic logic [11:0] exec_exp(logic [3:0] o, logic zz, logic cc);
    case (o)
      4'b0001: return SLacc | SAccA | 12'h008;
      4'b0010: return SLacc | SAccA | 12'h00C;
      4'b0011: return SLacc | SAccA | 12'h004;
      4'b1011: return SLacc | SAccA | 12'h001;
      4'b1100: return SLacc | SAccA | 12'h003;
      4'b0100: return SLreg;
      4'b0101: return SLacc | SAccR;
      4'b0110: return zz ? SLpc : 12'h000;
      4'b1000: return cc ? SLpc : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive(input int k, input logic rst, input logic [3:0] o, input logic zz,
                       input logic cc, input logic mr);
    @(posedge clk);
    #1;
    clb[k]    = rst;
    op        = o;
    z         = zz;
    c         = cc;
    mem_ready = mr;
    #3;
  endtask

  task automatic check_cycle(input int k, input string tag, input logic [11:0] es,
                             input logic eh, input logic ei);
    check({tag, ".strobes"}, 32'(got_strobes(k)), 32'(es));
    check({tag, ".halted"}, 32'(halted[k]), 32'(eh));
    check({tag, ".illegal"}, 32'(illegal[k]), 32'(ei));
    check({tag, ".count"}, 32'(cnt[k]), 32'(m_count));
  endtask

  function automatic void retire_one(int k);
    if (m_count < cmax_of(k)) m_count++;
  endfunction

  task automatic do_reset(input int k);
    m_count = 0;
    m_age   = 0;
    for (int i = 0; i < 2; i++) begin
      drive(k, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_cycle(k, "reset", 12'h000, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_fetch(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      drive(k, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check_cycle(k, "stall", 12'h000, 1'b0, 1'b0);
      m_age++;
    end
  endtask

  task automatic halted_check(input int k);
    for (int i = 0; i < 10; i++) begin
      drive(k, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_cycle(k, "halted", 12'h000, 1'b1, 1'b0);
    end
  endtask

  // One instruction: fetch with random stalls, execute, optional immediate phase.
  // fz/fc < 0 means random flags in EXEC; abort resets the DUT in the first IMM cycle.
  task automatic run_instr(input int k, input logic [3:0] o, input int fz, input int fc,
                           input bit abort, output bit stopped);
    logic zz, cc, mr;
    bit acc, tk, ill;
    logic [11:0] es;
    stopped = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mr = g_mr_hold || (m_age >= 40) || ($urandom_range(0, 3) != 0);
      drive(k, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), mr);
      acc = mr && (m_age >= wait_of(k));
      check_cycle(k, "fetch", acc ? (SIr | SInc) : 12'h000, 1'b0, 1'b0);
      m_age++;
      if (acc) break;
    end
    m_age = 0;
    zz = (fz < 0) ? 1'($urandom) : 1'(fz);
    cc = (fc < 0) ? 1'($urandom) : 1'(fc);
    drive(k, 1'b0, o, zz, cc, 1'($urandom));
    ill = (o == 4'b1001) || (o == 4'b1110);
    check_cycle(k, "exec", exec_exp(o, zz, cc), 1'b0, ill);
    if (o == 4'b1111 || (ill && trap_of(k))) begin
      stopped = 1'b1;
      return;
    end
    if (o == 4'b1101 || o == 4'b0111 || o == 4'b1010) begin
      tk = (o == 4'b0111) ? zz : (o == 4'b1010) ? cc : 1'b0;
      if (abort) begin
        m_count = 0;
        drive(k, 1'b1, o, 1'($urandom), 1'($urandom), 1'b1);
        check_cycle(k, "imm_rst", 12'h000, 1'b0, 1'b0);
        stopped = 1'b1;
        return;
      end
      for (int i = 0; i < 64; i++) begin
        mr = g_mr_hold || (m_age >= 40) || ($urandom_range(0, 3) != 0);
        drive(k, 1'b0, o, 1'($urandom), 1'($urandom), mr);
        acc = mr && (m_age >= wait_of(k));
        if (!acc)            es = 12'h000;
        else if (o == 4'b1101) es = SLacc | SInc | 12'h002;
        else if (tk)         es = SLpc | SSpc;
        else                 es = SInc;
        check_cycle(k, "imm", es, 1'b0, 1'b0);
        m_age++;
        if (acc) break;
      end
      m_age = 0;
    end
    retire_one(k);
  endtask

  task automatic run_random(input int k, input int n);
    bit st;
    for (int i = 0; i < n; i++) begin
      run_instr(k, 4'($urandom), -1, -1, 1'b0, st);
      if (st) begin
        halted_check(k);
        do_reset(k);
      end
    end
  endtask

  initial begin
    bit st;
    for (int k = 0; k < NI; k++) clb[k] = 1'b1;
    op        = 4'h0;
    z         = 1'b0;
    c         = 1'b0;
    mem_ready = 1'b0;
    g_mr_hold = 1'b0;

    // Defaults: directed plan, then random
    do_reset(0);
    g_mr_hold = 1'b1;
    run_instr(0, 4'b0001, -1, -1, 1'b0, st);
    check("add_count", 32'(cnt[0]), 32'd0);  // registered: still old value this cycle
    run_instr(0, 4'b0111, 1, -1, 1'b0, st);
    run_instr(0, 4'b1010, -1, 0, 1'b0, st);
    run_instr(0, 4'b1101, -1, -1, 1'b0, st);
    run_instr(0, 4'b0110, 0, -1, 1'b0, st);
    run_instr(0, 4'b1000, -1, 1, 1'b0, st);
    run_instr(0, 4'b1111, -1, -1, 1'b0, st);
    check("halt_stop", 32'(st), 32'd1);
    halted_check(0);
    do_reset(0);
    run_instr(0, 4'b1001, -1, -1, 1'b0, st);
    check("trap_stop", 32'(st), 32'd1);
    halted_check(0);
    do_reset(0);
    run_instr(0, 4'b0000, -1, -1, 1'b0, st);
    run_instr(0, 4'b0111, 1, -1, 1'b1, st);
    g_mr_hold = 1'b0;
    run_random(0, 60);
    clb[0] = 1'b1;

    // Wait states
    do_reset(1);
    g_mr_hold = 1'b1;
    run_instr(1, 4'b0010, -1, -1, 1'b0, st);
    g_mr_hold = 1'b0;
    idle_fetch(1, 5);
    g_mr_hold = 1'b1;
    run_instr(1, 4'b1101, -1, -1, 1'b0, st);
    g_mr_hold = 1'b0;
    run_random(1, 40);
    clb[1] = 1'b1;

    // Illegal as NOP
    do_reset(2);
    run_instr(2, 4'b1001, -1, -1, 1'b0, st);
    run_instr(2, 4'b1110, -1, -1, 1'b0, st);
    idle_fetch(2, 1);
    check("nop_ill_count", 32'(cnt[2]), 32'd2);
    run_random(2, 40);
    clb[2] = 1'b1;

    // Counter saturation
    do_reset(3);
    for (int i = 0; i < 5; i++) run_instr(3, 4'b0000, -1, -1, 1'b0, st);
    idle_fetch(3, 1);
    check("sat_count", 32'(cnt[3]), 32'd3);
    run_random(3, 30);
    clb[3] = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
